// File: rtl/booth_mul_seq.sv
// -----------------------------------------------------------------------------
// booth_mul_seq
//   Iterative radix-4 Booth multiplier core for MULT/MULTU in the EX stage.
//   Both 32-bit operands are sign- or zero-extended to 34 bits. One Booth
//   window per cycle goes to an external 2-bit Booth partial-product stage.
//   That stage returns a 68-bit partial product plus a correction bit. The
//   core accumulates these into a 68-bit sum. The low 64 bits of that sum
//   form the HI/LO result. The operation takes 17 iterations.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   mul_valid/ready   request handshake (ready only while idle)
//   mul_signed        1 = MULT (signed), 0 = MULTU
//   mul_x, mul_y      32-bit multiplicand / multiplier
//   mul_cancel        flush: abort any operation, return to idle
//   pp_x              34-bit extended multiplicand to the Booth stage
//   pp_y2/pp_y1/pp_y0 current Booth window {y[2i+1], y[2i], y[2i-1]}
//   pp_p, pp_c        68-bit partial product and correction bit from Booth stage
//   res_valid/ready   result handshake
//   res_hi, res_lo    product[63:32], product[31:0]
// -----------------------------------------------------------------------------
module booth_mul_seq #(
  parameter int ITER = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mul_valid,
  output logic        mul_ready,
  input  logic        mul_signed,
  input  logic [31:0] mul_x,
  input  logic [31:0] mul_y,
  input  logic        mul_cancel,
  output logic [33:0] pp_x,
  output logic        pp_y2,
  output logic        pp_y1,
  output logic        pp_y0,
  input  logic [67:0] pp_p,
  input  logic        pp_c,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [4:0] LAST_CNT = 5'(ITER - 1);

  state_e      state_q,     state_d;
  logic [33:0] xe_q,        xe_d;
  logic [33:0] ye_q,        ye_d;
  logic        yprev_q,     yprev_d;
  logic [67:0] acc_q,       acc_d;
  logic [4:0]  cnt_q,       cnt_d;
  logic        mul_ready_q, mul_ready_d;
  logic        res_valid_q, res_valid_d;

  logic [67:0] pp_sum_s;
  logic [67:0] pp_shift_s;
  logic        ext_x_s;
  logic        ext_y_s;

  // Weight the current partial product by 4^cnt; bits above 67 fall off.
  always_comb begin
    pp_sum_s   = pp_p + {67'd0, pp_c};
    pp_shift_s = pp_sum_s << {cnt_q, 1'b0};
    ext_x_s    = mul_signed & mul_x[31];
    ext_y_s    = mul_signed & mul_y[31];
  end

  // Next-state and datapath update; cancel takes priority over every state.
  always_comb begin
    state_d     = state_q;
    xe_d        = xe_q;
    ye_d        = ye_q;
    yprev_d     = yprev_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    mul_ready_d = mul_ready_q;
    res_valid_d = res_valid_q;

    if (mul_cancel) begin
      state_d     = S_IDLE;
      xe_d        = 34'd0;
      ye_d        = 34'd0;
      yprev_d     = 1'b0;
      acc_d       = 68'd0;
      cnt_d       = 5'd0;
      mul_ready_d = 1'b1;
      res_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mul_valid) begin
            state_d     = S_CALC;
            xe_d        = {{2{ext_x_s}}, mul_x};
            ye_d        = {{2{ext_y_s}}, mul_y};
            yprev_d     = 1'b0;
            acc_d       = 68'd0;
            cnt_d       = 5'd0;
            mul_ready_d = 1'b0;
            res_valid_d = 1'b0;
          end else begin
            mul_ready_d = 1'b1;
            res_valid_d = 1'b0;
          end
        end

        S_CALC: begin
          acc_d   = acc_q + pp_shift_s;
          // Arithmetic shift keeps the 34-bit sign in the upper windows.
          ye_d    = {ye_q[33], ye_q[33], ye_q[33:2]};
          yprev_d = ye_q[1];
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == LAST_CNT) begin
            // Window outputs read zero once the last window has been consumed.
            state_d     = S_DONE;
            xe_d        = 34'd0;
            ye_d        = 34'd0;
            yprev_d     = 1'b0;
            res_valid_d = 1'b1;
          end else begin
            state_d     = S_CALC;
          end
        end

        S_DONE: begin
          if (res_ready) begin
            state_d     = S_IDLE;
            mul_ready_d = 1'b1;
            res_valid_d = 1'b0;
          end else begin
            state_d     = S_DONE;
          end
        end

        default: begin
          state_d     = S_IDLE;
          xe_d        = 34'd0;
          ye_d        = 34'd0;
          yprev_d     = 1'b0;
          acc_d       = 68'd0;
          cnt_d       = 5'd0;
          mul_ready_d = 1'b1;
          res_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      xe_q        <= 34'd0;
      ye_q        <= 34'd0;
      yprev_q     <= 1'b0;
      acc_q       <= 68'd0;
      cnt_q       <= 5'd0;
      mul_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      xe_q        <= xe_d;
      ye_q        <= ye_d;
      yprev_q     <= yprev_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      mul_ready_q <= mul_ready_d;
      res_valid_q <= res_valid_d;
    end
  end

  // Window and result outputs are taken straight from flops.
  always_comb begin
    mul_ready = mul_ready_q;
    res_valid = res_valid_q;
    pp_x      = xe_q;
    pp_y2     = ye_q[1];
    pp_y1     = ye_q[0];
    pp_y0     = yprev_q;
    res_hi    = acc_q[63:32];
    res_lo    = acc_q[31:0];
  end

endmodule
